// File: rtl/axi4s_slave_rx_if.sv
// AXI4-Stream bundle shared by the stream master and slave blocks.
// tuser is carried for completeness; receivers may ignore it.
interface axi4s_if #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/axi4s_slave_rx.sv
// AXI4-Stream receiver: two-entry skid buffer into a FIFO-style consumer,
// with packet-length enforcement and beat/packet status counters.
module axi4s_slave_rx #(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BEATS  = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  axi4s_if.slave                       axi4s_slave_if,
  output logic [DATA_WIDTH-1:0]        fifo_data,
  output logic [DATA_WIDTH/8-1:0]      fifo_keep,
  output logic                         fifo_last,
  output logic                         fifo_valid,
  input  logic                         fifo_ready,
  output logic [$clog2(MAX_BEATS)-1:0] beat_count,
  output logic [CNT_WIDTH-1:0]         pkt_count,
  output logic                         len_err
);

  localparam int BC_W   = $clog2(MAX_BEATS);
  localparam int KEEP_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  tready_q;
  logic                  accept;
  logic                  fire;
  logic                  eff_last;
  logic                  load_m;
  logic                  m_from_s;
  logic                  load_s;

  logic [DATA_WIDTH-1:0] skid_data_p1;
  logic [KEEP_W-1:0]     skid_keep_p1;
  logic                  skid_last_p1;

  logic                  unused_tuser;

  assign unused_tuser          = ^axi4s_slave_if.tuser;
  assign axi4s_slave_if.tready = tready_q;

  assign accept     = axi4s_slave_if.tvalid && tready_q;
  assign fire       = fifo_valid && fifo_ready;
  assign fifo_valid = (state_q != ST_EMPTY);

  // A beat becomes the packet end either by tlast or by reaching the length cap
  assign eff_last = axi4s_slave_if.tlast || (beat_count == BC_W'(MAX_BEATS - 1));

  always_comb begin
    state_d  = state_q;
    load_m   = 1'b0;
    m_from_s = 1'b0;
    load_s   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_m  = 1'b1;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && fire) begin
          load_m = 1'b1;
        end else if (accept) begin
          load_s  = 1'b1;
          state_d = ST_TWO;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (fire) begin
          load_m   = 1'b1;
          m_from_s = 1'b1;
          state_d  = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Control: buffer occupancy, registered tready, length/packet counters
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_EMPTY;
      tready_q   <= 1'b0;
      beat_count <= '0;
      pkt_count  <= '0;
      len_err    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= (state_d != ST_TWO);
      len_err  <= accept && eff_last && !axi4s_slave_if.tlast;
      if (accept) begin
        if (eff_last) begin
          beat_count <= '0;
          pkt_count  <= pkt_count + 1'b1;
        end else begin
          beat_count <= beat_count + 1'b1;
        end
      end
    end
  end

  // Stage p0: main register, drives the consumer side directly
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo_data <= '0;
      fifo_keep <= '0;
      fifo_last <= 1'b0;
    end else if (load_m) begin
      fifo_data <= m_from_s ? skid_data_p1 : axi4s_slave_if.tdata;
      fifo_keep <= m_from_s ? skid_keep_p1 : axi4s_slave_if.tkeep;
      fifo_last <= m_from_s ? skid_last_p1 : eff_last;
    end
  end

  // Stage p1: skid register, only meaningful while occupancy is TWO
  always_ff @(posedge aclk) begin
    if (load_s) begin
      skid_data_p1 <= axi4s_slave_if.tdata;
      skid_keep_p1 <= axi4s_slave_if.tkeep;
      skid_last_p1 <= eff_last;
    end
  end

endmodule
